// File: rtl/ib_mul_seq.sv
// Sequencer for an external 8x8 serial multiplier with a result FIFO and busy timeout.
// Optional running product accumulator when IB_MUL_SEQ_ACC_EN is defined.
module ib_mul_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 31
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_mul_start,
    output logic [7:0]  o_mul_a,
    output logic [7:0]  o_mul_b,
    input  logic [15:0] i_mul_c,
    input  logic        i_mul_done,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_c,
    output logic        o_err
`ifdef IB_MUL_SEQ_ACC_EN
    ,
    input  logic        i_acc_clr,
    output logic [23:0] o_acc
`endif
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Only one operation is ever in flight, so a push cannot meet a full FIFO.
    assign push    = (state == S_BUSY) && i_mul_done;
    assign pop     = o_valid && i_ready;
    assign o_valid = (count != '0);
    assign o_ready = (state == S_IDLE) && (count < CW'(FIFO_DEPTH));
    assign o_c     = o_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_mul_start <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_err       <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        o_mul_a     <= i_a;
                        o_mul_b     <= i_b;
                        o_mul_start <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    o_mul_start <= 1'b0;
                    tmo_cnt     <= '0;
                    state       <= S_BUSY;
                end
                S_BUSY: begin
                    if (i_mul_done) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        // Abort once the counter would reach TIMEOUT; o_err is sticky.
                        if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                            o_err <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= i_mul_c;
    end

`ifdef IB_MUL_SEQ_ACC_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || i_acc_clr) o_acc <= '0;
        else if (push)          o_acc <= o_acc + {8'b0, i_mul_c};
    end
`endif

endmodule

// File: tb/tb_ib_mul_seq.sv
// Randomized bench for ib_mul_seq: behavioural multiplier plus a queue-based product scoreboard.
module tb_ib_mul_seq;
    localparam int DEPTH = 4;
    localparam int TMO   = 31;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_a = '0;
    logic [7:0]  i_b = '0;
    logic        o_mul_start;
    logic [7:0]  o_mul_a;
    logic [7:0]  o_mul_b;
    logic [15:0] i_mul_c = '0;
    logic        i_mul_done = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_c;
    logic        o_err;
`ifdef IB_MUL_SEQ_ACC_EN
    logic        i_acc_clr = 1'b0;
    logic [23:0] o_acc;
`endif

    always #5 i_clk = ~i_clk;

    ib_mul_seq #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .o_mul_start(o_mul_start), .o_mul_a(o_mul_a),
        .o_mul_b(o_mul_b), .i_mul_c(i_mul_c), .i_mul_done(i_mul_done),
        .o_valid(o_valid), .i_ready(i_ready), .o_c(o_c), .o_err(o_err)
`ifdef IB_MUL_SEQ_ACC_EN
        , .i_acc_clr(i_acc_clr), .o_acc(o_acc)
`endif
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    int          mul_cnt = 0;
    logic [7:0]  ma = '0;
    logic [7:0]  mb = '0;
    bit          mul_en = 1'b1;
    bit          hold_ok = 1'b0;
    bit          rnd_rdy = 1'b0;
    bit          lat_chk = 1'b0;
    bit          clr_on_done = 1'b0;
    int          start_cnt = 0;
    int          vld_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Entered at a falling edge with the caller's inputs set; advances one clock.
    task automatic cyc();
        bit done_drv;
        done_drv   = 1'b0;
        i_mul_done = 1'b0;
        i_mul_c    = 16'($urandom);
        if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) begin
                i_mul_done = 1'b1;
                i_mul_c    = {8'b0, ma} * {8'b0, mb};
                done_drv   = 1'b1;
                if (hold_ok) begin
                    chk("mul_a_hold", o_mul_a, ma);
                    chk("mul_b_hold", o_mul_b, mb);
                end
            end
        end
`ifdef IB_MUL_SEQ_ACC_EN
        i_acc_clr = done_drv && clr_on_done;
`endif
        if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
        if (lat_chk && done_drv) chk("vld_pre", o_valid, 0);
        if (o_valid) vld_cnt++;
        if (exp_q.size() == 0) chk("no_vld", o_valid, 0);
        else if (o_valid && i_ready) chk("pop_c", o_c, exp_q.pop_front());
        @(negedge i_clk);
        if (lat_chk && done_drv) begin
            chk("vld_lat", o_valid, 1);
            chk("vld_lat_c", o_c, {8'b0, ma} * {8'b0, mb});
        end
        if (o_mul_start) begin
            start_cnt++;
            if (mul_en) begin
                mul_cnt = 18;
                ma      = o_mul_a;
                mb      = o_mul_b;
                hold_ok = 1'b1;
            end
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_a = a;
        i_b = b;
        while (!o_ready && n < 300) begin
            cyc();
            n++;
        end
        chk("accept", o_ready, 1);
        exp_q.push_back({8'b0, a} * {8'b0, b});
        cyc();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cyc();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        exp_q.delete();
        hold_ok = 1'b0;
        cyc();
        chk("rst_vld", o_valid, 0);
        chk("rst_start", o_mul_start, 0);
        chk("rst_mul_a", o_mul_a, 0);
        chk("rst_mul_b", o_mul_b, 0);
        chk("rst_err", o_err, 0);
        chk("rst_c", o_c, 0);
        i_rst = 1'b0;
        cyc();
        chk("rst_ready", o_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge i_clk);
        do_reset();

        // single product, latency and pulse counts
        start_cnt = 0;
        vld_cnt   = 0;
        lat_chk   = 1'b1;
        i_ready   = 1'b1;
        send(8'd3, 8'd5);
        drain();
        repeat (3) cyc();
        lat_chk = 1'b0;
        chk("start_pulses", start_cnt, 1);
        chk("vld_cycles", vld_cnt, 1);
        chk("err_clean", o_err, 0);

        // extremes
        send(8'hFF, 8'hFF);
        send(8'h00, 8'hAB);
        drain();

        // backpressure: fill FIFO, then release
        i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 8'(i));
        repeat (20) cyc();
        chk("full_ready", o_ready, 0);
        chk("full_vld", o_valid, 1);
        chk("full_head", o_c, 16'd1);
        i_ready = 1'b1;
        send(8'd5, 8'd5);
        drain();

        // random traffic with random downstream stalls
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 25)) cyc();
        end
        rnd_rdy = 1'b0;
        i_ready = 1'b1;
        drain();

        // timeout: multiplier never answers
        mul_en = 1'b0;
        send(8'd9, 8'd9);
        void'(exp_q.pop_back());
        for (int i = 1; i <= TMO; i++) cyc();
        chk("tmo_err_early", o_err, 0);
        chk("tmo_ready_busy", o_ready, 0);
        cyc();
        chk("tmo_err", o_err, 1);
        chk("tmo_ready", o_ready, 1);
        chk("tmo_no_push", o_valid, 0);
        mul_en = 1'b1;
        send(8'd2, 8'd2);
        drain();
        chk("err_sticky", o_err, 1);
        do_reset();

        // reset mid-BUSY; the stale done must be ignored
        send(8'd7, 8'd9);
        repeat (5) cyc();
        do_reset();
        repeat (25) cyc();
        chk("stale_vld", o_valid, 0);
        chk("stale_idle", o_ready, 1);
        send(8'd6, 8'd7);
        drain();

`ifdef IB_MUL_SEQ_ACC_EN
        do_reset();
        send(8'd2, 8'd3);
        drain();
        chk("acc_6", o_acc, 24'd6);
        send(8'd4, 8'd5);
        drain();
        chk("acc_26", o_acc, 24'd26);
        send(8'h10, 8'h10);
        drain();
        chk("acc_282", o_acc, 24'd282);
        clr_on_done = 1'b1;
        send(8'd3, 8'd3);
        drain();
        clr_on_done = 1'b0;
        i_acc_clr = 1'b0;
        chk("acc_clr", o_acc, 24'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
